// File: rtl/adc_spi_capture.sv
// adc_spi_capture: turns a start request into one 16-clock SPI read frame,
// deserialises an 8-bit ADC sample and flags framing-bit violations.
module adc_spi_capture #(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned CS_SETUP = 4,
    parameter int unsigned CS_QUIET = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       sdata,
    output logic       cs_n,
    output logic       sclk,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        QUIET
    } state_t;

    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HALF_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] PER_LAST   = 16'(2 * CLK_DIV - 1);
    localparam logic [15:0] QUIET_LAST = 16'(CS_QUIET - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic [4:0]  bit_k;
    logic [4:0]  bit_k_nxt;
    logic [7:0]  sr;
    logic [7:0]  sr_nxt;
    logic        err;
    logic        err_nxt;
    logic        sclk_nxt;
    logic [2:0]  start_sync;
    logic [1:0]  sdata_sync;
    logic        req;
    logic        sd;

    // start_sync[2] is the previous synchronised value for edge detection
    assign req = start_sync[2] & ~start_sync[1];
    assign sd  = sdata_sync[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_sync <= '1;
            sdata_sync <= '1;
        end else begin
            start_sync <= {start_sync[1:0], start};
            sdata_sync <= {sdata_sync[0], sdata};
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_k_nxt = bit_k;
        sr_nxt    = sr;
        err_nxt   = err;
        sclk_nxt  = sclk;
        unique case (state)
            IDLE: begin
                sclk_nxt = 1'b1;
                if (req) begin
                    state_nxt = SETUP;
                    cnt_nxt   = '0;
                    sr_nxt    = '0;
                    err_nxt   = 1'b0;
                end
            end
            SETUP: begin
                if (cnt == SETUP_LAST) begin
                    state_nxt = SHIFT;
                    cnt_nxt   = '0;
                    bit_k_nxt = '0;
                    sclk_nxt  = 1'b0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            SHIFT: begin
                // Sample on the cycle sclk is driven 0->1
                if (cnt == HALF_LAST) begin
                    sclk_nxt  = 1'b1;
                    bit_k_nxt = bit_k + 5'd1;
                    if (bit_k >= 5'd3 && bit_k <= 5'd10) begin
                        sr_nxt = {sr[6:0], sd};
                    end else if (bit_k != 5'd15) begin
                        err_nxt = err | sd;
                    end
                end
                if (cnt == PER_LAST) begin
                    cnt_nxt = '0;
                    if (bit_k == 5'd16) begin
                        state_nxt = HOLD;
                        sclk_nxt  = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                    end
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            HOLD: begin
                state_nxt = QUIET;
                cnt_nxt   = '0;
            end
            QUIET: begin
                if (cnt == QUIET_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_k     <= '0;
            sr        <= '0;
            err       <= 1'b0;
            cs_n      <= 1'b1;
            sclk      <= 1'b1;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            bit_k     <= bit_k_nxt;
            sr        <= sr_nxt;
            err       <= err_nxt;
            cs_n      <= !(state_nxt == SETUP || state_nxt == SHIFT);
            sclk      <= sclk_nxt;
            busy      <= (state_nxt != IDLE);
            valid     <= (state_nxt == HOLD);
            frame_err <= (state_nxt == HOLD) & err_nxt;
            if (state_nxt == HOLD) begin
                data <= sr_nxt;
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
// tb_adc_spi_capture: randomized bench for adc_spi_capture with an ADC pin
// model and a word-level reference of the expected sample and framing flag.
module tb_adc_spi_capture;

    localparam int CLK_DIV  = 8;
    localparam int CS_SETUP = 4;
    localparam int CS_QUIET = 8;
    // busy rises one cycle after the request is detected
    localparam int LAT      = CS_SETUP + 32 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b1;
    logic       sdata = 1'b1;
    logic       cs_n;
    logic       sclk;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] adc_word = '0;
    int          bit_idx = 0;
    int          cyc = 0;
    int          rises = 0;
    int          csf = 0;
    int          vhigh = 0;
    int          data_jumps = 0;
    int          pin_viol = 0;
    logic [7:0]  data_prev = '0;
    logic        cs_prev = 1'b1;
    logic        sclk_prev = 1'b1;

    adc_spi_capture #(
        .CLK_DIV (CLK_DIV),
        .CS_SETUP(CS_SETUP),
        .CS_QUIET(CS_QUIET)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sdata    (sdata),
        .cs_n     (cs_n),
        .sclk     (sclk),
        .data     (data),
        .valid    (valid),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC pins: next frame bit after each sclk fall, MSB of the word first
    always @(negedge sclk or negedge cs_n or posedge cs_n) begin
        if (cs_n) begin
            sdata   = 1'b1;
            bit_idx = 0;
        end else if (!sclk && bit_idx < 16) begin
            sdata   = adc_word[15 - bit_idx];
            bit_idx = bit_idx + 1;
        end
    end

    always @(posedge sclk) if (!cs_n) rises = rises + 1;
    always @(negedge cs_n) csf = csf + 1;

    always @(negedge clk) begin
        if (valid) vhigh = vhigh + 1;
        if (!rst && !valid && data !== data_prev) data_jumps = data_jumps + 1;
        if (!rst && cs_n && !sclk) pin_viol = pin_viol + 1;
        if (!rst && cs_n !== cs_prev && (!sclk || !sclk_prev)) pin_viol = pin_viol + 1;
        data_prev = data;
        cs_prev   = cs_n;
        sclk_prev = sclk;
    end

    function automatic logic [7:0] ref_data(input logic [15:0] w);
        return w[12:5];
    endfunction

    function automatic logic ref_err(input logic [15:0] w);
        return (|w[15:13]) | (|w[4:1]);
    endfunction

    task automatic run_frame(input logic [15:0] w, input bit glitch,
                             output int gap, output logic [7:0] d,
                             output logic fe, output int nr, output int nv,
                             output int nc, output bit tout);
        int r0, v0, c0, tb_, tv, off;
        adc_word = w;
        r0 = rises; v0 = vhigh; c0 = csf;
        tb_ = -1; tv = -1; d = '0; fe = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b1;
            if (busy && tb_ < 0) tb_ = cyc;
            if (valid) begin
                tv = cyc;
                d  = data;
                fe = frame_err;
            end
            if (glitch && tb_ >= 0) begin
                off = cyc - tb_;
                if (off == 40 || off == 150 || off == 262) start = 1'b0;
                if (off == 43 || off == 153 || off == 265) start = 1'b1;
            end
            if (tb_ >= 0 && !busy) break;
        end
        start = 1'b1;
        tout = (tb_ < 0) || busy;
        gap  = tv - tb_;
        nr   = rises - r0;
        nv   = vhigh - v0;
        nc   = csf - c0;
    endtask

    task automatic check_frame(input string nm, input logic [15:0] w,
                               input bit glitch);
        int gap, nr, nv, nc;
        logic [7:0] d;
        logic fe;
        bit tout;
        run_frame(w, glitch, gap, d, fe, nr, nv, nc, tout);
        checks++;
        if (tout !== 1'b0) begin
            errors++;
            $display("FAIL %s timeout: got %0d required 0", nm, tout);
        end
        checks++;
        if (gap !== LAT) begin
            errors++;
            $display("FAIL %s latency: got %0d required %0d", nm, gap, LAT);
        end
        checks++;
        if (d !== ref_data(w)) begin
            errors++;
            $display("FAIL %s data: got %0h required %0h", nm, d, ref_data(w));
        end
        checks++;
        if (fe !== ref_err(w)) begin
            errors++;
            $display("FAIL %s frame_err: got %0b required %0b", nm, fe, ref_err(w));
        end
        checks++;
        if (nr !== 16) begin
            errors++;
            $display("FAIL %s sclk_rises: got %0d required 16", nm, nr);
        end
        checks++;
        if (nv !== 1) begin
            errors++;
            $display("FAIL %s valid_cycles: got %0d required 1", nm, nv);
        end
        checks++;
        if (nc !== 1) begin
            errors++;
            $display("FAIL %s cs_frames: got %0d required 1", nm, nc);
        end
        checks++;
        if (data !== ref_data(w)) begin
            errors++;
            $display("FAIL %s data_after: got %0h required %0h", nm, data, ref_data(w));
        end
    endtask

    task automatic test_reset;
        logic [12:0] obs;
        logic [12:0] idle_exp;
        idle_exp = {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        obs = {cs_n, sclk, data, valid, busy, frame_err};
        checks++;
        if (obs !== idle_exp) begin
            errors++;
            $display("FAIL reset_state: got %0h required %0h", obs, idle_exp);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            obs = {cs_n, sclk, data, valid, busy, frame_err};
            checks++;
            if (obs !== idle_exp) begin
                errors++;
                $display("FAIL idle_state: got %0h required %0h", obs, idle_exp);
            end
        end
    endtask

    task automatic test_basic;
        check_frame("basic_93", {3'b000, 8'h93, 5'b00000}, 1'b0);
    endtask

    task automatic test_second;
        repeat (50) @(negedge clk);
        checks++;
        if (data !== 8'h93) begin
            errors++;
            $display("FAIL held_93: got %0h required 93", data);
        end
        check_frame("second_3a", {3'b000, 8'h3A, 5'b00000}, 1'b0);
    endtask

    task automatic test_frame_err;
        check_frame("lead_k1", {3'b010, 8'h55, 5'b00000}, 1'b0);
        check_frame("trail_k15", {3'b000, 8'hA5, 5'b00001}, 1'b0);
        check_frame("trail_k14", {3'b000, 8'h0F, 5'b00010}, 1'b0);
        check_frame("lead_k0", {3'b100, 8'hF0, 5'b00000}, 1'b0);
    endtask

    task automatic test_back_to_back;
        int c0;
        c0 = csf;
        check_frame("glitch_c6", {3'b000, 8'hC6, 5'b00000}, 1'b1);
        repeat (40) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || csf - c0 !== 1) begin
            errors++;
            $display("FAIL glitch_extra: got busy=%0b frames=%0d required busy=0 frames=1",
                     busy, csf - c0);
        end
    endtask

    task automatic test_held_low;
        int c0, v0;
        adc_word = {3'b000, 8'h6D, 5'b00000};
        c0 = csf; v0 = vhigh;
        @(negedge clk);
        start = 1'b0;
        repeat (700) @(negedge clk);
        start = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (csf - c0 !== 1 || vhigh - v0 !== 1) begin
            errors++;
            $display("FAIL held_low: got frames=%0d valids=%0d required 1 1",
                     csf - c0, vhigh - v0);
        end
        checks++;
        if (data !== 8'h6D) begin
            errors++;
            $display("FAIL held_low_data: got %0h required 6d", data);
        end
    endtask

    task automatic test_reset_midframe;
        int r0, c0, v0;
        bit reached;
        logic [3:0] obs;
        adc_word = {3'b000, 8'hE7, 5'b00000};
        r0 = rises;
        reached = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i == 3) start = 1'b1;
            if (rises - r0 >= 7 && !sclk) begin
                reached = 1'b1;
                break;
            end
        end
        start = 1'b1;
        checks++;
        if (!reached) begin
            errors++;
            $display("FAIL rst_mid_reach: got %0d rises required 7", rises - r0);
        end
        #2 rst = 1'b1;
        #1;
        obs = {cs_n, sclk, valid, busy};
        checks++;
        if (obs !== 4'b1100 || data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_pins: got %0b data %0h required 1100 data 0",
                     obs, data);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        c0 = csf; v0 = vhigh;
        repeat (300) @(negedge clk);
        checks++;
        if (csf !== c0 || vhigh !== v0 || data !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_quiet: got frames=%0d valids=%0d data=%0h required 0 0 0",
                     csf - c0, vhigh - v0, data);
        end
        check_frame("after_rst", {3'b000, 8'h81, 5'b00000}, 1'b0);
    endtask

    task automatic test_random;
        logic [15:0] w;
        logic [2:0] lead;
        logic [4:0] trail;
        for (int n = 0; n < 12; n++) begin
            lead  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
            trail = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b00000;
            w = {lead, 8'($urandom), trail};
            repeat ($urandom_range(0, 20)) @(negedge clk);
            check_frame("random", w, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_second();
        test_frame_err();
        test_back_to_back();
        test_held_low();
        test_reset_midframe();
        test_random();
        checks++;
        if (data_jumps !== 0) begin
            errors++;
            $display("FAIL data_hold: got %0d changes required 0", data_jumps);
        end
        checks++;
        if (pin_viol !== 0) begin
            errors++;
            $display("FAIL cs_sclk_order: got %0d violations required 0", pin_viol);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
